// File: rtl/parking_display_scanner.sv
// Converts a binary free-slot count to BCD (serial double-dabble) and scans it onto a
// 4-digit common-anode display; the scan and blink square waves are sampled, never used as clocks.
module parking_display_scanner #(
  parameter int VALUE_W  = 14,
  parameter int MAX_DISP = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_clk,
  input  logic               blink_clk,
  input  logic [VALUE_W-1:0] value,
  input  logic               blink_en,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               busy,
  output logic               ovf
);

  localparam int SR_W  = 16 + VALUE_W;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [VALUE_W-1:0] MAX_V    = VALUE_W'(MAX_DISP);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(VALUE_W - 1);
  localparam logic [6:0]         SEG_DASH = 7'b0111111;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic               s1, s2, b1, b2;
  logic               tick;
  logic [1:0]         idx;
  logic [1:0]         state;
  logic [VALUE_W-1:0] cap;
  logic               ovf_pending;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_adj;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        disp;
  logic [3:0]         blank;
  logic [3:0]         dig;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign tick = s1 & ~s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      b1  <= 1'b0;
      b2  <= 1'b0;
      idx <= 2'd0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      b1 <= blink_clk;
      b2 <= b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 4; k++) begin
      if (sr[VALUE_W + 4*k +: 4] >= 4'd5)
        sr_adj[VALUE_W + 4*k +: 4] = sr[VALUE_W + 4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cap         <= '0;
      ovf_pending <= 1'b0;
      sr          <= '0;
      cnt         <= '0;
      disp        <= '0;
      busy        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value != cap) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          cap         <= value;
          ovf_pending <= (value > MAX_V);
          if (value > MAX_V) begin
            state <= DONE;
          end else begin
            sr    <= {16'd0, value};
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr <= {sr_adj[SR_W-2:0], 1'b0};
          if (cnt == LAST_CNT) state <= DONE;
          else                 cnt   <= cnt + CNT_W'(1);
        end
        default: begin
          if (!ovf_pending) disp <= sr[SR_W-1 -: 16];
          ovf   <= ovf_pending;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A digit above the units is blank when it and every higher digit are zero.
  always_comb begin
    blank[3] = (disp[15:12] == 4'd0);
    blank[2] = blank[3] && (disp[11:8] == 4'd0);
    blank[1] = blank[2] && (disp[7:4] == 4'd0);
    blank[0] = 1'b0;
    dig      = disp[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else if ((blank[idx] && !ovf) || (blink_en && !b2)) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= ovf ? SEG_DASH : decode(dig);
    end
  end

endmodule

// File: tb/tb_parking_display_scanner.sv
// Randomised and directed bench for parking_display_scanner against an arithmetic display model.
module tb_parking_display_scanner;

  logic        clk = 1'b1;
  logic        reset, scan_clk, blink_clk, blink_en;
  logic [13:0] value;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy, ovf;

  int passes = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parking_display_scanner dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .blink_clk(blink_clk),
    .value(value), .blink_en(blink_en), .an(an), .seg(seg), .busy(busy), .ovf(ovf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: what the display must show, derived from decimal arithmetic.
  int         p10[4] = '{1, 10, 100, 1000};
  int         m_idx, m_age, m_cap, m_disp;
  bit         m_sc1, m_sc2, m_bl1, m_bl2, m_busy, m_ovfp, m_ovf, m_valid;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  task automatic model_step(input bit r, input bit sc, input bit bk, input bit ben, input int v);
    int  d;
    bit  blank;
    if (!r) begin
      m_idx = 0; m_age = 0; m_cap = 0; m_disp = 0;
      m_sc1 = 0; m_sc2 = 0; m_bl1 = 0; m_bl2 = 0;
      m_busy = 0; m_ovfp = 0; m_ovf = 0;
      m_an = 4'hF; m_seg = 7'h7F; m_valid = 1;
      return;
    end
    d     = (m_disp / p10[m_idx]) % 10;
    blank = !m_ovf && m_idx > 0 && m_disp < p10[m_idx];
    if (blank || (ben && !m_bl2)) begin
      m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      m_an  = 4'hF & ~(4'b0001 << m_idx);
      m_seg = m_ovf ? seg_of(10) : seg_of(d);
    end
    if (m_sc1 && !m_sc2) m_idx = (m_idx + 1) % 4;
    if (!m_busy) begin
      if (v != m_cap) begin
        m_busy = 1; m_age = 0;
      end
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_cap = v; m_ovfp = (v > 9999);
      end
      if (m_age == (m_ovfp ? 2 : 16)) begin
        if (!m_ovfp) m_disp = m_cap;
        m_ovf = m_ovfp; m_busy = 0;
      end
    end
    m_sc2 = m_sc1; m_sc1 = sc; m_bl2 = m_bl1; m_bl1 = bk;
  endtask

  // Inputs change 2 units after each rising edge, so at the falling edge the
  // current inputs are the ones the next rising edge will sample.
  initial begin
    bit pr, psc, pbk, pben, have;
    int pv;
    have = 0;
    forever begin
      @(negedge clk);
      if (have) begin
        model_step(pr, psc, pbk, pben, pv);
        if (m_valid) begin
          chk("an", an, m_an);
          chk("seg", seg, m_seg);
          chk("busy", busy, m_busy);
          chk("ovf", ovf, m_ovf);
        end
      end
      pr = reset; psc = scan_clk; pbk = blink_clk; pben = blink_en; pv = value;
      have = 1;
    end
  end

  int scan_half = 4, scan_cnt = 0, blink_half = 23, blink_cnt = 0;
  int low_run = 0, high_run = 0;
  bit rnd_scan = 0;

  task automatic cyc();
    if (blink_clk) begin high_run++; low_run = 0; end
    else begin low_run++; high_run = 0; end
    @(posedge clk);
    #2;
    scan_cnt++;
    if (scan_cnt >= scan_half) begin
      scan_clk = ~scan_clk; scan_cnt = 0;
      if (rnd_scan) scan_half = $urandom_range(1, 6);
    end
    blink_cnt++;
    if (blink_cnt >= blink_half) begin
      blink_clk = ~blink_clk; blink_cnt = 0;
      if (rnd_scan) blink_half = $urandom_range(3, 15);
    end
  endtask

  task automatic wait_conv(input string nm, output int n);
    bit fell;
    n = 0; fell = 0;
    for (int i = 0; i < 200 && !fell; i++) begin
      cyc();
      if (busy) n++;
      else if (n > 0) fell = 1;
    end
    if (!fell) chk({nm, "_timeout"}, 0, 1);
  endtask

  // exp holds {d3,d2,d1,d0} segment patterns; mask marks digits that must stay dark.
  task automatic check_digits(input string nm, input logic [27:0] exp, input logic [3:0] mask);
    logic [6:0] sg[4];
    bit         any[4];
    int         odd;
    odd = 0;
    for (int k = 0; k < 4; k++) begin sg[k] = '0; any[k] = 0; end
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (an != 4'hF && an != 4'hE && an != 4'hD && an != 4'hB && an != 4'h7) odd++;
      for (int k = 0; k < 4; k++)
        if (an == (4'hF & ~(4'b0001 << k))) begin any[k] = 1; sg[k] = seg; end
    end
    chk({nm, "_anodes"}, odd, 0);
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) chk($sformatf("%s_blank%0d", nm, k), any[k], 0);
      else begin
        chk($sformatf("%s_lit%0d", nm, k), any[k], 1);
        chk($sformatf("%s_seg%0d", nm, k), sg[k], exp[7*k +: 7]);
      end
    end
  endtask

  initial begin
    int n, bad, good;
    reset = 0; value = 0; blink_en = 0; scan_clk = 0; blink_clk = 0;
    repeat (3) cyc();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1;

    n = 0;
    repeat (32) begin cyc(); if (busy) n++; end
    chk("zero_nobusy", n, 0);
    check_digits("zero", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1110);

    value = 1234;
    wait_conv("t1234", n);
    chk("t1234_busylen", n, 16);
    chk("t1234_ovf", ovf, 0);
    check_digits("t1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b0000);

    value = 305;
    wait_conv("t305", n);
    check_digits("t305", {7'h7F, 7'b0110000, 7'b1000000, 7'b0010010}, 4'b1000);

    value = 12000;
    wait_conv("t12000", n);
    chk("t12000_busylen", n, 2);
    chk("t12000_ovf", ovf, 1);
    check_digits("t12000", {4{7'b0111111}}, 4'b0000);
    value = 7;
    wait_conv("t7", n);
    chk("t7_ovf", ovf, 0);
    check_digits("t7", {7'h7F, 7'h7F, 7'h7F, 7'b1111000}, 4'b1110);

    value = 42;
    wait_conv("t42", n);
    blink_en = 1; blink_half = 10;
    bad = 0; good = 0;
    repeat (200) begin
      cyc();
      if (low_run >= 3 && an != 4'hF) bad++;
      if (high_run >= 3 && an != 4'hF) good++;
    end
    chk("blink_dark", bad, 0);
    chk("blink_lit", good > 0, 1);
    blink_en = 0;
    check_digits("t42", {7'h7F, 7'h7F, 7'b0011001, 7'b0100100}, 4'b1100);

    value = 0;
    wait_conv("t0", n);
    value = 42;
    cyc(); cyc();
    repeat (5) cyc();
    value = 57;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin cyc(); n++; end
    chk("t57_first_done", busy, 0);
    cyc();
    chk("t57_rebusy", busy, 1);
    wait_conv("t57", n);
    check_digits("t57", {7'h7F, 7'h7F, 7'b0010010, 7'b1111000}, 4'b1100);

    value = 8888;
    repeat (6) cyc();
    reset = 0; value = 0;
    cyc();
    reset = 1;
    cyc();
    chk("abort_busy", busy, 0);
    check_digits("abort", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1110);

    rnd_scan = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0)
        value = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                            : 14'($urandom_range(0, 9999));
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      reset = ($urandom_range(0, 399) != 0);
      cyc();
    end
    reset = 1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
